// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency RV32I data-memory responder.
// Accepts one load/store per handshake and pulses one response after LATENCY cycles.
// Ports:
//   clk, reset (async, active-high)
//   req_valid/req_ready handshake; req_we, req_addr, req_wdata, req_funct3
//   resp_valid strobe with resp_rdata (extended load data) and resp_err
module dmem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY > 1 ? LATENCY - 2 : 0);

    state_t state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic enter_resp;

    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [2:0]  lat_f3;

    logic        cur_we;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [2:0]  cur_f3;

    logic [31:0] mem [2**ADDR_WIDTH];

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]  lane;
    logic [31:0] mem_word;
    logic [31:0] shifted;
    logic [15:0] half_v;
    logic [31:0] load_data;
    logic [31:0] wdata_rep;
    logic [3:0]  wmask;
    logic [31:0] new_word;
    logic        illegal;
    logic        misal;
    logic        err;
    logic        unused_addr;

    // With LATENCY==1 RESP is entered straight from IDLE, so the
    // response must be computed from the live request in that cycle.
    assign cur_we    = (state == IDLE) ? req_we     : lat_we;
    assign cur_addr  = (state == IDLE) ? req_addr   : lat_addr;
    assign cur_wdata = (state == IDLE) ? req_wdata  : lat_wdata;
    assign cur_f3    = (state == IDLE) ? req_funct3 : lat_f3;

    assign word_idx    = cur_addr[ADDR_WIDTH+1:2];
    assign lane        = cur_addr[1:0];
    assign unused_addr = ^cur_addr[31:ADDR_WIDTH+2];
    assign mem_word    = mem[word_idx];

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        enter_resp = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_nx   = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx   = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        illegal = 1'b0;
        misal   = 1'b0;
        unique case (cur_f3)
            3'b000: ;
            3'b001: misal = lane[0];
            3'b101: begin
                misal   = lane[0];
                illegal = cur_we;
            end
            3'b010: misal = (lane != 2'b00);
            3'b100: illegal = cur_we;
            default: illegal = 1'b1;
        endcase
    end

    assign err = illegal | misal;

    assign shifted = mem_word >> {lane, 3'b000};
    assign half_v  = lane[1] ? mem_word[31:16] : mem_word[15:0];

    always_comb begin
        load_data = 32'd0;
        unique case (cur_f3[1:0])
            2'b00: load_data = cur_f3[2] ? {24'd0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            2'b01: load_data = cur_f3[2] ? {16'd0, half_v}
                                         : {{16{half_v[15]}}, half_v};
            2'b10: load_data = mem_word;
            default: load_data = 32'd0;
        endcase
    end

    always_comb begin
        wdata_rep = cur_wdata;
        wmask     = 4'b1111;
        unique case (cur_f3[1:0])
            2'b00: begin
                wdata_rep = {4{cur_wdata[7:0]}};
                wmask     = 4'b0001 << lane;
            end
            2'b01: begin
                wdata_rep = {2{cur_wdata[15:0]}};
                wmask     = lane[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata_rep = cur_wdata;
                wmask     = 4'b1111;
            end
        endcase
        for (int b = 0; b < 4; b++) begin
            new_word[8*b +: 8] = wmask[b] ? wdata_rep[8*b +: 8]
                                          : mem_word[8*b +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            lat_we     <= 1'b0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            lat_f3     <= 3'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == IDLE && req_valid) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_f3    <= req_funct3;
            end
            if (enter_resp) begin
                resp_rdata <= (cur_we || err) ? 32'd0 : load_data;
                resp_err   <= err;
            end else begin
                resp_rdata <= 32'd0;
                resp_err   <= 1'b0;
            end
        end
    end

    // Array is not reset; reset held across the commit edge blocks the write.
    always_ff @(posedge clk) begin
        if (enter_resp && cur_we && !err && !reset) begin
            mem[word_idx] <= new_word;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder.
// Covers byte/half/word access, extension, errors, throughput and reset abort.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;

    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        v1, rdy1, we1;
    logic [31:0] addr1, wd1;
    logic [2:0]  f31;
    logic        rv1;
    logic [31:0] rd1;
    logic        re1;

    int total = 0;
    int bad   = 0;

    logic [9:0]  rmask, vmask;
    logic        seen;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err)
    );

    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(v1), .req_ready(rdy1),
        .req_we(we1), .req_addr(addr1),
        .req_wdata(wd1), .req_funct3(f31),
        .resp_valid(rv1), .resp_rdata(rd1),
        .resp_err(re1)
    );

    task automatic check(input logic [31:0] obs,
                         input logic [31:0] exp,
                         input string tag);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request on the LATENCY=2 instance; checks latency and result.
    task automatic access(input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] f3,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input string tag);
        int lat;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = a;
        req_wdata  = wd;
        req_funct3 = f3;
        check(32'(req_ready), 32'd1, {tag, "_ready"});
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            check(resp_rdata, 32'd0, {tag, "_idle_rdata"});
            @(negedge clk);
            lat++;
        end
        check(32'(lat), 32'd2, {tag, "_latency"});
        check(resp_rdata, exp_rd, {tag, "_rdata"});
        check(32'(resp_err), 32'(exp_err), {tag, "_err"});
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_funct3 = 0;
        v1 = 0; we1 = 0; addr1 = 0; wd1 = 0; f31 = 0;
        @(negedge clk);
        @(negedge clk);
        check(32'(req_ready), 32'd1, "rst_ready");
        check(32'(resp_valid), 32'd0, "rst_valid");
        check(resp_rdata, 32'd0, "rst_rdata");
        check(32'(resp_err), 32'd0, "rst_err");
        reset = 1'b0;

        access(1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 0, "sw1");
        access(0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 0, "lw1");
        access(0, 32'h1010, 32'h0, 3'b010, 32'hDEADBEEF, 0, "lw_alias");

        access(1, 32'h10, 32'h0, 3'b010, 32'h0, 0, "sw0");
        access(1, 32'h13, 32'h80, 3'b000, 32'h0, 0, "sb");
        access(0, 32'h10, 32'h0, 3'b010, 32'h80000000, 0, "lw_sb");
        access(0, 32'h13, 32'h0, 3'b000, 32'hFFFFFF80, 0, "lb");
        access(0, 32'h13, 32'h0, 3'b100, 32'h00000080, 0, "lbu");

        access(1, 32'h14, 32'h0, 3'b010, 32'h0, 0, "sw14");
        access(1, 32'h16, 32'h8001, 3'b001, 32'h0, 0, "sh");
        access(0, 32'h16, 32'h0, 3'b001, 32'hFFFF8001, 0, "lh");
        access(0, 32'h16, 32'h0, 3'b101, 32'h00008001, 0, "lhu");
        access(0, 32'h14, 32'h0, 3'b010, 32'h80010000, 0, "lw_sh");

        access(0, 32'h12, 32'h0, 3'b010, 32'h0, 1, "lw_mis");
        access(1, 32'h11, 32'h1234, 3'b010, 32'h0, 1, "sw_mis");
        access(0, 32'h10, 32'h0, 3'b010, 32'h80000000, 0, "lw_unch");
        access(0, 32'h10, 32'h0, 3'b011, 32'h0, 1, "ld_ill");
        access(1, 32'h10, 32'h5, 3'b011, 32'h0, 1, "st_ill");
        access(0, 32'h11, 32'h0, 3'b001, 32'h0, 1, "lh_mis");
        access(0, 32'h10, 32'h0, 3'b010, 32'h80000000, 0, "lw_unch2");

        access(1, 32'hFFC, 32'hCAFEF00D, 3'b010, 32'h0, 0, "sw_top");
        access(0, 32'hFFC, 32'h0, 3'b010, 32'hCAFEF00D, 0, "lw_top");

        // Held request, LATENCY=2: accepts every 3 cycles.
        @(negedge clk);
        req_valid = 1; req_we = 0; req_addr = 32'h10; req_funct3 = 3'b010;
        for (int i = 0; i < 10; i++) begin
            rmask[i] = req_ready;
            vmask[i] = resp_valid;
            @(negedge clk);
        end
        req_valid = 0;
        check(32'(rmask), 32'h249, "hold2_ready");
        check(32'(vmask), 32'h124, "hold2_resp");
        repeat (3) @(negedge clk);

        // Held request, LATENCY=1: accepts every 2 cycles.
        v1 = 1; we1 = 1; addr1 = 32'h0; wd1 = 32'h11; f31 = 3'b010;
        for (int i = 0; i < 10; i++) begin
            rmask[i] = rdy1;
            vmask[i] = rv1;
            @(negedge clk);
        end
        check(32'(rmask), 32'h155, "hold1_ready");
        check(32'(vmask), 32'h2AA, "hold1_resp");
        we1 = 0; addr1 = 32'h0; f31 = 3'b010;
        @(negedge clk);
        v1 = 0;
        check(32'(rv1), 32'd1, "lat1_valid");
        check(rd1, 32'h11, "lat1_rdata");
        @(negedge clk);
        check(32'(rv1), 32'd0, "lat1_single");

        // Reset during WAIT drops the store.
        access(1, 32'h20, 32'h12345678, 3'b010, 32'h0, 0, "sw20");
        @(negedge clk);
        req_valid = 1; req_we = 1; req_addr = 32'h20;
        req_wdata = 32'hAAAA5555; req_funct3 = 3'b010;
        @(negedge clk);
        req_valid = 0;
        check(32'(req_ready), 32'd0, "abort_wait");
        reset = 1'b1;
        #1;
        check(32'(req_ready), 32'd1, "abort_ready");
        check(32'(resp_valid), 32'd0, "abort_valid");
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | resp_valid;
        end
        check(32'(seen), 32'd0, "abort_noresp");
        access(0, 32'h20, 32'h0, 3'b010, 32'h12345678, 0, "lw_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
